// File: rtl/load_unit.sv
// Load unit: accepts one load request at a time, checks alignment, issues a
// read on the data bus, then extracts and extends the addressed field from
// the returned 64-bit word and holds it until the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new request (req_ready=1)
// REQ   | read request on the bus, waiting for address acceptance
// WAIT  | address accepted, waiting for read data
// DONE  | result (or misalignment error) held on out_* until out_ready
module load_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_msize,
   input  logic        req_unsigned,
   output logic        dreq_valid,
   output logic [63:0] dreq_addr,
   output logic [1:0]  dreq_size,
   output logic [7:0]  dreq_strobe,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [63:0] dresp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_err
);

   // access size encoding: byte count = 1 << msize
   localparam logic [1:0] MSIZE1 = 2'd0;
   localparam logic [1:0] MSIZE2 = 2'd1;
   localparam logic [1:0] MSIZE4 = 2'd2;
   localparam logic [1:0] MSIZE8 = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [63:0] r_addr;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [63:0] r_out_data;
   logic        r_err;

   logic        w_accept;
   logic        w_misaligned;
   logic        w_capture;
   logic [5:0]  w_shift;
   logic [63:0] w_shifted;
   logic [63:0] w_result;

   logic        w_req_ready;
   logic        w_dreq_valid;
   logic        w_out_valid;

   assign w_accept = (r_state == S_IDLE) && req_valid;

   // capture only in REQ (with address accept) or WAIT; data_ok elsewhere is dropped
   assign w_capture = ((r_state == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((r_state == S_WAIT) && dresp_data_ok);

   // alignment check on the incoming request, evaluated at accept time
   always_comb begin
      w_misaligned = 1'b0;
      case (req_msize)
         MSIZE1:  w_misaligned = 1'b0;
         MSIZE2:  w_misaligned = req_addr[0];
         MSIZE4:  w_misaligned = |req_addr[1:0];
         MSIZE8:  w_misaligned = |req_addr[2:0];
         default: w_misaligned = 1'b0;
      endcase
   end

   // bring the addressed field down to bit 0 of the bus word
   always_comb begin
      w_shift = 6'd0;
      case (r_size)
         MSIZE1:  w_shift = {r_addr[2:0], 3'b000};
         MSIZE2:  w_shift = {r_addr[2:1], 4'b0000};
         MSIZE4:  w_shift = {r_addr[2], 5'b00000};
         MSIZE8:  w_shift = 6'd0;
         default: w_shift = 6'd0;
      endcase
      w_shifted = dresp_data >> w_shift;
   end

   // sign- or zero-extend the extracted field to 64 bits
   always_comb begin
      w_result = w_shifted;
      case (r_size)
         MSIZE1:  w_result = {{56{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
         MSIZE2:  w_result = {{48{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         MSIZE4:  w_result = {{32{~r_unsigned & w_shifted[31]}}, w_shifted[31:0]};
         MSIZE8:  w_result = w_shifted;
         default: w_result = w_shifted;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_nxt = w_misaligned ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (dresp_addr_ok) begin
               w_state_nxt = dresp_data_ok ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (dresp_data_ok) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state-decoded handshake outputs
   always_comb begin
      w_req_ready  = 1'b0;
      w_dreq_valid = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         S_IDLE:  w_req_ready  = 1'b1;
         S_REQ:   w_dreq_valid = 1'b1;
         S_WAIT:  w_dreq_valid = 1'b0;
         S_DONE:  w_out_valid  = 1'b1;
         default: w_req_ready  = 1'b0;
      endcase
   end

   // request fields latch on accept and hold through the access
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr     <= 64'd0;
         r_size     <= MSIZE1;
         r_unsigned <= 1'b0;
      end else if (w_accept) begin
         r_addr     <= req_addr;
         r_size     <= req_msize;
         r_unsigned <= req_unsigned;
      end
   end

   // result register: cleared on accept (error path leaves it zero), loaded on capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_data <= 64'd0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_out_data <= 64'd0;
         r_err      <= w_misaligned;
      end else if (w_capture) begin
         r_out_data <= w_result;
         r_err      <= 1'b0;
      end
   end

   assign req_ready   = w_req_ready;
   assign dreq_valid  = w_dreq_valid;
   assign dreq_addr   = r_addr;
   assign dreq_size   = r_size;
   assign dreq_strobe = 8'h00;
   assign out_valid   = w_out_valid;
   assign out_data    = r_out_data;
   assign out_err     = r_err;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed scenarios plus randomized loads checked
// against an arithmetic reference model of the load result.
module tb_load_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [1:0]  req_msize;
   logic        req_unsigned;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_err;

   int total = 0;
   int bad   = 0;

   load_unit dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_msize    (req_msize),
      .req_unsigned (req_unsigned),
      .dreq_valid   (dreq_valid),
      .dreq_addr    (dreq_addr),
      .dreq_size    (dreq_size),
      .dreq_strobe  (dreq_strobe),
      .dresp_addr_ok(dresp_addr_ok),
      .dresp_data_ok(dresp_data_ok),
      .dresp_data   (dresp_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_err      (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: byte-count arithmetic on the spec's alignment/extension rules
   function automatic logic [63:0] model(input logic [63:0] a, input logic [1:0] sz,
                                         input logic u, input logic [63:0] d,
                                         output logic err);
      int nb;
      int off;
      logic [63:0] v;
      logic [63:0] mask;
      nb  = 1 << sz;
      off = int'(a % 64'd8);
      err = (a % nb) != 0;
      if (err) return 64'd0;
      v = d >> (8 * off);
      if (nb < 8) begin
         mask = (64'd1 << (8 * nb)) - 64'd1;
         v = v & mask;
         if (!u && v[8*nb-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // One complete load; starts and ends at a negedge with the unit idle.
   // ao_dly: cycles REQ waits for addr_ok; do_dly: cycles from addr_ok to data_ok
   // (0 = same cycle); rdy_dly: cycles out_ready is held low in DONE.
   task automatic do_load(input logic [63:0] a, input logic [1:0] sz, input logic u,
                          input logic [63:0] d, input int ao_dly, input int do_dly,
                          input int rdy_dly, input string tag);
      logic        exp_err;
      logic [63:0] exp_data;
      exp_data = model(a, sz, u, d, exp_err);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL %s req_ready_idle got=%b exp=1", tag, req_ready);
      end
      req_valid = 1'b1; req_addr = a; req_msize = sz; req_unsigned = u;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom}; req_msize = 2'($urandom); req_unsigned = 1'($urandom);
      if (!exp_err) begin
         for (int i = 0; i < ao_dly; i++) begin
            total++;
            if (dreq_valid !== 1'b1 || dreq_addr !== a || dreq_size !== sz || dreq_strobe !== 8'h00) begin
               bad++;
               $display("FAIL %s dreq_stall got=%b/%h/%0d/%h exp=1/%h/%0d/00", tag,
                        dreq_valid, dreq_addr, dreq_size, dreq_strobe, a, sz);
            end
            @(negedge clk);
         end
         total++;
         if (dreq_valid !== 1'b1 || dreq_addr !== a || dreq_size !== sz) begin
            bad++;
            $display("FAIL %s dreq got=%b/%h/%0d exp=1/%h/%0d", tag, dreq_valid, dreq_addr, dreq_size, a, sz);
         end
         dresp_addr_ok = 1'b1;
         dresp_data_ok = (do_dly == 0);
         dresp_data    = (do_dly == 0) ? d : {$urandom, $urandom};
         @(negedge clk);
         dresp_addr_ok = 1'b0;
         dresp_data_ok = 1'b0;
         if (do_dly > 0) begin
            for (int i = 1; i < do_dly; i++) begin
               total++;
               if (dreq_valid !== 1'b0 || out_valid !== 1'b0) begin
                  bad++;
                  $display("FAIL %s wait got dreq_valid=%b out_valid=%b exp=0/0", tag, dreq_valid, out_valid);
               end
               dresp_data = {$urandom, $urandom};
               @(negedge clk);
            end
            dresp_data_ok = 1'b1;
            dresp_data    = d;
            @(negedge clk);
            dresp_data_ok = 1'b0;
         end
      end else begin
         total++;
         if (dreq_valid !== 1'b0) begin
            bad++; $display("FAIL %s misaligned_dreq got=%b exp=0", tag, dreq_valid);
         end
      end
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_data || out_err !== exp_err) begin
         bad++;
         $display("FAIL %s result got=%b/%h/%b exp=1/%h/%b", tag, out_valid, out_data, out_err, exp_data, exp_err);
      end
      for (int i = 0; i < rdy_dly; i++) begin
         dresp_data_ok = 1'($urandom);
         dresp_data    = {$urandom, $urandom};
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_data !== exp_data || out_err !== exp_err ||
             req_ready !== 1'b0 || dreq_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s hold got=%b/%h/%b rr=%b dv=%b exp=1/%h/%b rr=0 dv=0", tag,
                     out_valid, out_data, out_err, req_ready, dreq_valid, exp_data, exp_err);
         end
      end
      dresp_data_ok = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s release got out_valid=%b req_ready=%b exp=0/1", tag, out_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b0; req_addr = 64'd0; req_msize = 2'd0; req_unsigned = 1'b0;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total++;
      if (req_ready !== 1'b1 || dreq_valid !== 1'b0 || out_valid !== 1'b0 ||
          out_data !== 64'd0 || out_err !== 1'b0 || dreq_addr !== 64'd0 ||
          dreq_size !== 2'd0 || dreq_strobe !== 8'h00) begin
         bad++;
         $display("FAIL reset_state got rr=%b dv=%b ov=%b od=%h oe=%b da=%h ds=%0d st=%h exp=1/0/0/0/0/0/0/00",
                  req_ready, dreq_valid, out_valid, out_data, out_err, dreq_addr, dreq_size, dreq_strobe);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      // byte sign-extend, minimum latency
      do_load(64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 0, 0, 0, "byte_signed");
      // word zero-extend, addr_ok cycle 1, data_ok cycle 4
      do_load(64'h2004, 2'd2, 1'b1, 64'hDEAD_BEEF_0000_0000, 0, 3, 0, "word_wait");
      // misaligned halfword
      do_load(64'h3003, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, "half_misaligned");
      // dword with address stall
      do_load(64'h4000, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 3, 0, 0, "dword_stall");
      // misaligned word and dword
      do_load(64'h5002, 2'd2, 1'b1, 64'h1, 0, 0, 1, "word_misaligned");
      do_load(64'h6004, 2'd3, 1'b1, 64'h1, 0, 0, 1, "dword_misaligned");
      // halfword at top of word, signed
      do_load(64'h7006, 2'd1, 1'b0, 64'h8123_0000_0000_0000, 0, 1, 0, "half_top");
   endtask

   task automatic test_hold();
      do_load(64'h8005, 2'd0, 1'b1, 64'h00AB_CD00_0000_0000, 1, 0, 5, "hold5");
   endtask

   task automatic test_reset_in_wait();
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL rst_wait_start got=%b exp=1", req_ready);
      end
      req_valid = 1'b1; req_addr = 64'h9000; req_msize = 2'd3; req_unsigned = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      dresp_addr_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      total++;
      if (dreq_valid !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait_in_wait got dv=%b ov=%b rr=%b exp=0/0/0", dreq_valid, out_valid, req_ready);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      dresp_data_ok = 1'b1;
      dresp_data = 64'hCAFE_F00D_1234_5678;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (out_valid !== 1'b0 || req_ready !== 1'b1 || dreq_valid !== 1'b0 ||
             out_data !== 64'd0 || out_err !== 1'b0 || dreq_addr !== 64'd0) begin
            bad++;
            $display("FAIL rst_wait_after got ov=%b rr=%b dv=%b od=%h oe=%b da=%h exp=0/1/0/0/0/0",
                     out_valid, req_ready, dreq_valid, out_data, out_err, dreq_addr);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      do_load(64'hA001, 2'd0, 1'b0, 64'h0000_0000_0000_7F00, 0, 0, 0, "b2b_0");
      do_load(64'hA00C, 2'd2, 1'b0, 64'h9000_0001_0000_0000, 0, 0, 0, "b2b_1");
      do_load(64'hA00E, 2'd1, 1'b1, 64'hF00F_0000_0000_0000, 2, 2, 0, "b2b_2");
   endtask

   task automatic test_random();
      logic [63:0] a;
      logic [1:0]  sz;
      for (int n = 0; n < 60; n++) begin
         a  = {$urandom, $urandom};
         sz = 2'($urandom);
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         do_load(a, sz, 1'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  load request from memory stage.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_addr  input  64  byte address (u64).
REQ-007 req_msize  input  msize_t  MSIZE1/2/4/8.
REQ-008 req_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
REQ-009 dreq_valid  output  1  data-bus read request.
REQ-010 dreq_addr  output  64  latched request address.
REQ-011 dreq_size  output  msize_t  latched size.
REQ-012 dreq_strobe  output  strobe_t  always 8'h00 (read).
REQ-013 dresp_addr_ok  input  1  bus accepted address.
REQ-014 dresp_data_ok  input  1  read data valid.
REQ-015 dresp_data  input  64  full aligned 64-bit bus word.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer takes result.
REQ-018 out_data  output  64  aligned, extended load result.
REQ-019 out_err  output  1  misaligned access flagged.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DONE; req_ready=1 only in IDLE.
REQ-021 IDLE + req_valid: latch addr, msize, unsigned; misaligned -> DONE with err=1, data=0, no bus request; else -> REQ.
REQ-022 Misaligned: MSIZE2 addr[0]!=0; MSIZE4 addr[1:0]!=0; MSIZE8 addr[2:0]!=0; MSIZE1 never.
REQ-023 REQ: dreq_valid=1, addr/size stable; addr_ok without data_ok -> WAIT; addr_ok with data_ok same cycle -> capture data, DONE; no addr_ok -> stay.
REQ-024 WAIT: dreq_valid=0; data_ok -> capture data, DONE; else stay.
REQ-025 data_ok in IDLE or DONE SHALL be ignored.
REQ-026 Extraction: MSIZE1 byte = data[8*addr[2:0]+:8]; MSIZE2 data[16*addr[2:1]+:16]; MSIZE4 data[32*addr[2]+:32]; MSIZE8 full word.
REQ-027 Extension to 64 bits: sign-extend from top bit of extracted field if unsigned=0, else zero-extend; MSIZE8 unaffected.
REQ-028 Result SHALL be registered on capture; out_data/out_err stable while out_valid=1.
REQ-029 DONE: out_valid=1; out_ready -> IDLE next cycle; new request accepted no earlier than that IDLE cycle.
REQ-030 Minimum latency: accept at cycle 0, REQ cycle 1 (addr_ok+data_ok), out_valid at cycle 2.

Reset
REQ-031 reset SHALL force IDLE; req_ready=1; dreq_valid=0; out_valid=0; out_data=0; out_err=0; latched fields=0.
REQ-032 Reset in REQ/WAIT/DONE SHALL abandon the access; a data_ok arriving after reset is ignored.

Verification
REQ-033 MSIZE1 signed, addr=0x1003, dresp_data=0x0000_0000_8000_0000, addr_ok+data_ok same cycle -> out_data=0xFFFF_FFFF_FFFF_FF80, err=0, out_valid at cycle 2.
REQ-034 MSIZE4 unsigned, addr=0x2004, data=0xDEAD_BEEF_0000_0000, addr_ok cycle 1, data_ok cycle 4 -> out_data=0x0000_0000_DEAD_BEEF.
REQ-035 MSIZE2 addr=0x3003 -> no dreq_valid ever, out_valid=1, out_err=1, out_data=0.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid and out_data stable, req_ready=0 throughout.
REQ-037 reset asserted in WAIT, data_ok pulsed next cycle -> out_valid stays 0, req_ready=1.
REQ-038 MSIZE8 addr=0x4000, data=0x0123_4567_89AB_CDEF, addr_ok stalled 3 cycles -> dreq_addr stable, out_data=0x0123_4567_89AB_CDEF.
